// File: rtl/alu_pkg.sv
// Shared constants for the ALU arbiter: opcode encodings, FSM state encoding
// and the default datapath width.
package alu_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;
    localparam logic [2:0] OP_NAND = 3'b110;
    localparam logic [2:0] OP_NOR  = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping from NREQ-1 back to 0.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDXW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDXW-1:0] grant_idx,
    output logic            any_req
);

    int              cand;
    logic [IDXW-1:0] cand_idx;
    logic            found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand     = (int'(ptr) + k) % NREQ;
            cand_idx = IDXW'(cand);
            if (!found && req[cand_idx]) begin
                found           = 1'b1;
                grant[cand_idx] = 1'b1;
                grant_idx       = cand_idx;
            end
        end
        any_req = |req;
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU core among NREQ requesters with a
// rotating-priority grant and a registered, tagged response channel.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for any req_valid; grant + latch operands on entry
// EXEC    | operand registers drive the ALU core; result captured
// RESP    | rsp_valid held with frozen result until rsp_ready
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*WIDTH-1:0]     req_a,
    input  logic [NREQ*WIDTH-1:0]     req_b,
    input  logic [NREQ*3-1:0]         req_op,
    output logic [WIDTH-1:0]          alu_a,
    output logic [WIDTH-1:0]          alu_b,
    output logic [2:0]                alu_sel,
    input  logic [WIDTH-1:0]          alu_out,
    input  logic                      alu_carry,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [WIDTH-1:0]          rsp_data,
    output logic                      rsp_carry,
    output logic                      busy
);

    localparam int IDXW = $clog2(NREQ);

    logic [1:0]       state_q,     state_d;
    logic [IDXW-1:0]  ptr_q,       ptr_d;
    logic [IDXW-1:0]  id_q,        id_d;
    logic [WIDTH-1:0] a_q,         a_d;
    logic [WIDTH-1:0] b_q,         b_d;
    logic [2:0]       op_q,        op_d;
    logic [WIDTH-1:0] rsp_data_q,  rsp_data_d;
    logic             rsp_carry_q, rsp_carry_d;

    logic [NREQ-1:0]  grant;
    logic [IDXW-1:0]  grant_idx;
    logic             any_req;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_req   (any_req)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        rsp_data_d  = rsp_data_q;
        rsp_carry_d = rsp_carry_q;
        req_ready   = '0;

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    req_ready = grant;
                    id_d      = grant_idx;
                    a_d       = req_a[grant_idx*WIDTH +: WIDTH];
                    b_d       = req_b[grant_idx*WIDTH +: WIDTH];
                    op_d      = req_op[grant_idx*3 +: 3];
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_data_d  = alu_out;
                rsp_carry_d = alu_carry;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                // Pointer moves past the owner only once the response is
                // consumed, so a re-requesting client queues behind others.
                if (rsp_ready) begin
                    ptr_d   = (id_q == IDXW'(NREQ - 1)) ? '0 : id_q + 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            rsp_data_q  <= '0;
            rsp_carry_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            rsp_data_q  <= rsp_data_d;
            rsp_carry_q <= rsp_carry_d;
        end
    end

    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_sel   = op_q;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_id    = id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_carry = rsp_carry_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
